// File: rtl/mvm_pkg.sv
// Shared constants and state type for the MVM result unpacking path.
package mvm_pkg;

  localparam int DATAW      = 512;
  localparam int OPRECISION = 32;
  localparam int NWORDS     = DATAW / OPRECISION;
  localparam int LANEW      = $clog2(NWORDS);
  localparam int DESTW      = 12;
  localparam int USERW      = 75;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/mvm_result_unpacker.sv
// Splits one wide MVM result beat into a stream of OPRECISION-wide words,
// one lane per cycle, with the next beat accepted on the final lane handshake.
module mvm_result_unpacker
  import mvm_pkg::*;
#(
  parameter int DATAW      = mvm_pkg::DATAW,
  parameter int OPRECISION = mvm_pkg::OPRECISION,
  parameter int DESTW      = mvm_pkg::DESTW,
  parameter int USERW      = mvm_pkg::USERW
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             axis_rx_tvalid,
  input  logic [DATAW-1:0]                 axis_rx_tdata,
  input  logic [DESTW-1:0]                 axis_rx_tdest,
  input  logic [USERW-1:0]                 axis_rx_tuser,
  input  logic                             axis_rx_tlast,
  output logic                             axis_rx_tready,
  input  logic [$clog2(DATAW/OPRECISION):0] cfg_words,
  output logic                             out_valid,
  output logic [OPRECISION-1:0]            out_data,
  output logic [$clog2(DATAW/OPRECISION)-1:0] out_lane,
  output logic [DESTW-1:0]                 out_dest,
  output logic                             out_last,
  input  logic                             out_ready,
  output logic [15:0]                      beats_rx
);

  localparam int NWORDS = DATAW / OPRECISION;
  localparam int LANEW  = $clog2(NWORDS);
  localparam logic [LANEW:0] NW_CNT = (LANEW+1)'(NWORDS);

  state_e             state_q, state_d;
  logic [DATAW-1:0]   data_q, data_d;
  logic [DESTW-1:0]   dest_q, dest_d;
  logic [USERW-1:0]   tuser_unused_q, tuser_unused_d;
  logic               last_q, last_d;
  logic [LANEW:0]     n_q, n_d;
  logic [LANEW-1:0]   idx_q, idx_d;
  logic [15:0]        beats_q, beats_d;

  logic               lane_last;
  logic               word_acc;
  logic               rx_acc;
  logic [LANEW:0]     n_eff;

  // Out-of-range word counts collapse to a full beat.
  assign n_eff     = (cfg_words == '0 || cfg_words > NW_CNT) ? NW_CNT : cfg_words;
  assign lane_last = ({1'b0, idx_q} == (n_q - 1'b1));
  assign word_acc  = (state_q == DRAIN) && out_ready;

  // Ready reaches back through out_ready so the next beat lands with no bubble.
  assign axis_rx_tready = rst && ((state_q == IDLE) || (word_acc && lane_last));
  assign rx_acc         = axis_rx_tvalid && axis_rx_tready;

  assign out_valid = (state_q == DRAIN);
  assign out_data  = data_q[idx_q*OPRECISION +: OPRECISION];
  assign out_lane  = idx_q;
  assign out_dest  = dest_q;
  assign out_last  = out_valid && lane_last && last_q;
  assign beats_rx  = beats_q;

  // NOTE: every next-state value is defaulted to its current value first, so
  // no path through this block can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    data_d         = data_q;
    dest_d         = dest_q;
    tuser_unused_d = tuser_unused_q;
    last_d         = last_q;
    n_d            = n_q;
    idx_d          = idx_q;
    beats_d        = beats_q;

    if (rx_acc) begin
      state_d        = DRAIN;
      data_d         = axis_rx_tdata;
      dest_d         = axis_rx_tdest;
      tuser_unused_d = axis_rx_tuser;
      last_d         = axis_rx_tlast;
      n_d            = n_eff;
      idx_d          = '0;
      if (beats_q != 16'hFFFF) beats_d = beats_q + 16'd1;
    end else if (word_acc) begin
      if (lane_last) begin
        state_d = IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // NOTE: the beat register is a plain flop bank, not a RAM, so it is cleared
  // with the rest of the state; that keeps out_data at zero after reset.
  // All state updates use non-blocking assignment so every flop samples the
  // same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      data_q         <= '0;
      dest_q         <= '0;
      tuser_unused_q <= '0;
      last_q         <= 1'b0;
      n_q            <= NW_CNT;
      idx_q          <= '0;
      beats_q        <= '0;
    end else begin
      state_q        <= state_d;
      data_q         <= data_d;
      dest_q         <= dest_d;
      tuser_unused_q <= tuser_unused_d;
      last_q         <= last_d;
      n_q            <= n_d;
      idx_q          <= idx_d;
      beats_q        <= beats_d;
    end
  end

endmodule
